register_file_reader: RTL and testbench
=======================================

Name: register_file_reader

Overview:
- Architectural integer register file for the RISC-V core: DEPTH entries of WIDTH bits.
- One write port from writeback; two registered read ports (rs1, rs2) feeding the decode/execute pipeline register.
- Each read port has a read-enable; its value output holds when the enable is low.
- Same-cycle write-to-read bypass, so the pipeline never reads a stale value.

Parameters:
WIDTH, 32, data width of each register
DEPTH, 32, number of architectural registers
ADDR_WIDTH, 5, address width; DEPTH must be <= 2**ADDR_WIDTH
ZERO_REG, 1, when 1, entry 0 always reads 0 and writes to it are discarded (RISC-V x0)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
write_enable  input  1  commit rd_value into entry rd_addr at the next rising edge
rd_addr  input  ADDR_WIDTH  write address
rd_value  input  WIDTH  write data
rs1_enable  input  1  capture a new rs1 read at the next rising edge
rs1_addr  input  ADDR_WIDTH  read address, port 1
rs1_value  output  WIDTH  registered read data, port 1
rs2_enable  input  1  capture a new rs2 read at the next rising edge
rs2_addr  input  ADDR_WIDTH  read address, port 2
rs2_value  output  WIDTH  registered read data, port 2

Behaviour:
- Reset (reset low, asynchronous): all DEPTH entries = 0; rs1_value = rs2_value = 0 immediately.
- While reset is low, writes and reads are ignored. The first capturing edge is the first rising clock with reset high.
- Write, at the rising edge with write_enable=1:
  - entry[rd_addr] <= rd_value.
  - Discarded if ZERO_REG=1 and rd_addr=0.
  - Discarded if rd_addr >= DEPTH.
- Read latency is 1 cycle. At the rising edge with rsN_enable=1, rsN_value <= the first matching case below, in priority order:
  1. 0, if ZERO_REG=1 and rsN_addr=0.
  2. 0, if rsN_addr >= DEPTH.
  3. rd_value (bypass), if write_enable=1 and rd_addr=rsN_addr and the write is not discarded.
  4. Otherwise entry[rsN_addr], the pre-edge contents.
- rsN_enable=0: rsN_value holds its previous value, even if the entry it came from is later overwritten. No implicit refresh.
- Port independence:
  - Both ports may read the same address in the same cycle; both receive identical data.
  - A read and a write to different addresses in the same cycle do not interact.
- Arithmetic: none. Addresses are compared at full ADDR_WIDTH with no truncation or wrap-around. Data is stored and returned unmodified.
- ZERO_REG=0: entry 0 is an ordinary register, covered by the write and bypass rules like any other entry.
- Reset mid-operation:
  - Any write presented in the same cycle as reset assertion is lost.
  - Outputs read 0 until the next enabled read after reset is released.
- Storage: flops, no initial contents beyond reset. Simulation initial values match the reset values.

Test Plan:
- Reset then read. Pulse reset low; release; read rs1_addr=5, rs2_addr=31 with both enables=1 -> both values = 0 one cycle later.
- Write then read.
  - Write 0xDEADBEEF to entry 7.
  - Next cycle, rs1_addr=7 enabled -> rs1_value=0xDEADBEEF.
  - rs2_addr=8 -> rs2_value=0.
- Bypass.
  - Entry 3 holds 0x11111111.
  - In one cycle: write 0x22222222 to entry 3, rs1_addr=3, rs2_addr=3, both enabled.
  - Next cycle: both values = 0x22222222, and entry 3 later reads 0x22222222.
- x0 handling.
  - Write 0xFFFFFFFF to rd_addr=0 while reading rs1_addr=0 in the same cycle -> rs1_value=0.
  - Later read of entry 0 -> 0.
  - Repeat with ZERO_REG=0 -> bypass gives 0xFFFFFFFF and entry 0 then reads 0xFFFFFFFF.
- Hold on disable.
  - Read entry 9 = 0x00000AAA into rs1.
  - Drop rs1_enable; write 0x00000BBB to entry 9 and change rs1_addr to 10.
  - rs1_value stays 0x00000AAA.
  - Re-enable rs1_addr=9 -> next cycle rs1_value=0x00000BBB.
- Async reset mid-stream.
  - rs1_value=0x12345678; assert reset between clock edges -> rs1_value=0 before the next edge.
  - A write issued during reset does not land: entry reads 0 after release.
  - With DEPTH=16, read addr 20 -> 0; write addr 20 -> no entry changes.

Source files
------------

// File: rtl/register_file_reader.sv
// rtl/register_file_reader.sv - integer register file, one write port, two registered read ports
// Same-cycle writes bypass into the read ports; discarded writes (x0, out-of-range) never bypass.
module register_file_reader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [WIDTH-1:0]      rd_value,
  input  logic                  rs1_enable,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic [WIDTH-1:0]      rs1_value,
  input  logic                  rs2_enable,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [WIDTH-1:0]      rs2_value
);

  localparam int SLOTS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];

  logic [WIDTH-1:0] entry [SLOTS];
  logic             write_ok;
  logic [WIDTH-1:0] rs1_d, rs1_q;
  logic [WIDTH-1:0] rs2_d, rs2_q;

  always_comb begin
    write_ok = write_enable && ({1'b0, rd_addr} < DEPTH_L);
    if ((ZERO_REG != 0) && (rd_addr == '0)) write_ok = 1'b0;
  end

  // Slots that can never hold data (x0, beyond DEPTH) are constant zero,
  // which makes the zero-read rules fall out of a plain array lookup.
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    if ((i < DEPTH) && !((ZERO_REG != 0) && (i == 0))) begin : g_reg
      logic [WIDTH-1:0] value_q;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          value_q <= '0;
        end else if (write_ok && (rd_addr == ADDR_WIDTH'(i))) begin
          value_q <= rd_value;
        end
      end
      assign entry[i] = value_q;
    end else begin : g_const
      assign entry[i] = '0;
    end
  end

  always_comb begin
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    if (rs1_enable) begin
      rs1_d = entry[rs1_addr];
      if (write_ok && (rd_addr == rs1_addr)) rs1_d = rd_value;
    end
    if (rs2_enable) begin
      rs2_d = entry[rs2_addr];
      if (write_ok && (rd_addr == rs2_addr)) rs2_d = rd_value;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
    end
  end

  assign rs1_value = rs1_q;
  assign rs2_value = rs2_q;

endmodule

// File: tb/tb_register_file_reader.sv
// tb/tb_register_file_reader.sv - bench for register_file_reader in three configurations
// Instances: 0 = default, 1 = ZERO_REG=0, 2 = DEPTH=16.
module tb_register_file_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        write_enable = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_value = '0;
  logic        rs1_enable = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic        rs2_enable = 1'b0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] r1 [3];
  logic [31:0] r2 [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  register_file_reader #(.WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut_a (
    .clock(clock), .reset(reset), .write_enable(write_enable), .rd_addr(rd_addr),
    .rd_value(rd_value), .rs1_enable(rs1_enable), .rs1_addr(rs1_addr), .rs1_value(r1[0]),
    .rs2_enable(rs2_enable), .rs2_addr(rs2_addr), .rs2_value(r2[0]));

  register_file_reader #(.WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dut_b (
    .clock(clock), .reset(reset), .write_enable(write_enable), .rd_addr(rd_addr),
    .rd_value(rd_value), .rs1_enable(rs1_enable), .rs1_addr(rs1_addr), .rs1_value(r1[1]),
    .rs2_enable(rs2_enable), .rs2_addr(rs2_addr), .rs2_value(r2[1]));

  register_file_reader #(.WIDTH(32), .DEPTH(16), .ADDR_WIDTH(5), .ZERO_REG(1)) dut_c (
    .clock(clock), .reset(reset), .write_enable(write_enable), .rd_addr(rd_addr),
    .rd_value(rd_value), .rs1_enable(rs1_enable), .rs1_addr(rs1_addr), .rs1_value(r1[2]),
    .rs2_enable(rs2_enable), .rs2_addr(rs2_addr), .rs2_value(r2[2]));

  int          depth_c [3] = '{32, 32, 16};
  int          zr_c    [3] = '{1, 0, 1};
  logic [31:0] mem     [3][32];
  logic [31:0] e1      [3];
  logic [31:0] e2      [3];

  initial begin
    for (int c = 0; c < 3; c++) begin
      e1[c] = '0;
      e2[c] = '0;
      for (int i = 0; i < 32; i++) mem[c][i] = '0;
    end
  end

  function automatic bit write_lands(int c);
    if (!write_enable) return 1'b0;
    if (int'(rd_addr) >= depth_c[c]) return 1'b0;
    if (zr_c[c] != 0 && rd_addr == 5'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_read(int c, logic [4:0] a);
    if (zr_c[c] != 0 && a == 5'd0) return 32'h0;
    if (int'(a) >= depth_c[c]) return 32'h0;
    if (write_lands(c) && rd_addr == a) return rd_value;
    return mem[c][a];
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 3; c++) begin
        e1[c] = '0;
        e2[c] = '0;
        for (int i = 0; i < 32; i++) mem[c][i] = '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        logic [31:0] n1, n2;
        n1 = rs1_enable ? model_read(c, rs1_addr) : e1[c];
        n2 = rs2_enable ? model_read(c, rs2_addr) : e2[c];
        if (write_lands(c)) mem[c][rd_addr] = rd_value;
        e1[c] = n1;
        e2[c] = n2;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("model_rs1_dut%0d", c), r1[c], e1[c]);
      chk($sformatf("model_rs2_dut%0d", c), r2[c], e2[c]);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    write_enable = 1'b0;
    rs1_enable   = 1'b0;
    rs2_enable   = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    write_enable = 1'b1;
    rd_addr      = a;
    rd_value     = v;
  endtask

  initial begin
    repeat (3) step();
    chk("reset_rs1", r1[0], 32'h0);
    chk("reset_rs2", r2[0], 32'h0);
    reset = 1'b1;

    rs1_enable = 1'b1; rs1_addr = 5'd5;
    rs2_enable = 1'b1; rs2_addr = 5'd31;
    step();
    chk("first_read_rs1", r1[0], 32'h0);
    chk("first_read_rs2", r2[0], 32'h0);

    idle(); wr(5'd7, 32'hDEADBEEF);
    step();
    idle(); rs1_enable = 1'b1; rs1_addr = 5'd7; rs2_enable = 1'b1; rs2_addr = 5'd8;
    step();
    chk("write_read_rs1", r1[0], 32'hDEADBEEF);
    chk("write_read_rs2", r2[0], 32'h0);

    idle(); wr(5'd3, 32'h11111111);
    step();
    wr(5'd3, 32'h22222222);
    rs1_enable = 1'b1; rs1_addr = 5'd3; rs2_enable = 1'b1; rs2_addr = 5'd3;
    step();
    chk("bypass_rs1", r1[0], 32'h22222222);
    chk("bypass_rs2", r2[0], 32'h22222222);
    write_enable = 1'b0;
    step();
    chk("bypass_stored", r1[0], 32'h22222222);

    idle(); wr(5'd0, 32'hFFFFFFFF); rs1_enable = 1'b1; rs1_addr = 5'd0;
    step();
    chk("x0_bypass_zr1", r1[0], 32'h0);
    chk("x0_bypass_zr0", r1[1], 32'hFFFFFFFF);
    write_enable = 1'b0;
    step();
    chk("x0_read_zr1", r1[0], 32'h0);
    chk("x0_read_zr0", r1[1], 32'hFFFFFFFF);

    idle(); wr(5'd9, 32'h00000AAA);
    step();
    idle(); rs1_enable = 1'b1; rs1_addr = 5'd9;
    step();
    chk("hold_initial", r1[0], 32'h00000AAA);
    rs1_enable = 1'b0; rs1_addr = 5'd10; wr(5'd9, 32'h00000BBB);
    step();
    chk("hold_during_write", r1[0], 32'h00000AAA);
    write_enable = 1'b0;
    step();
    chk("hold_after_write", r1[0], 32'h00000AAA);
    rs1_enable = 1'b1; rs1_addr = 5'd9;
    step();
    chk("hold_reenable", r1[0], 32'h00000BBB);

    idle(); wr(5'd20, 32'hCAFEF00D); rs1_enable = 1'b1; rs1_addr = 5'd20;
    step();
    chk("oob_bypass_d16", r1[2], 32'h0);
    chk("oob_bypass_d32", r1[0], 32'hCAFEF00D);
    write_enable = 1'b0; rs1_addr = 5'd4;
    step();
    chk("oob_alias_d16", r1[2], 32'h0);

    idle(); wr(5'd4, 32'h12345678);
    step();
    idle(); rs1_enable = 1'b1; rs1_addr = 5'd4;
    step();
    chk("pre_reset_rs1", r1[0], 32'h12345678);
    idle();
    #2 reset = 1'b0;
    #1;
    chk("async_reset_rs1", r1[0], 32'h0);
    wr(5'd4, 32'h55555555);
    step();
    step();
    reset = 1'b1; idle(); rs1_enable = 1'b1; rs1_addr = 5'd4;
    step();
    chk("write_in_reset_lost", r1[0], 32'h0);

    for (int n = 0; n < 2000; n++) begin
      write_enable = ($urandom_range(0, 3) != 0);
      rd_addr      = 5'($urandom_range(0, 31));
      rd_value     = $urandom;
      rs1_enable   = ($urandom_range(0, 3) != 0);
      rs2_enable   = ($urandom_range(0, 3) != 0);
      rs1_addr     = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      rs2_addr     = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
      step();
      if (!reset) begin
        reset = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b0;
        #1;
        chk("rand_reset_rs1", r1[0], 32'h0);
        chk("rand_reset_rs2", r2[1], 32'h0);
      end
    end

    idle();
    reset = 1'b1;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
